alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational 8-bit ALU: same 6-bit funct-style opcode set, generic operand width.
- Adds a valid/ready operation handshake, status flags and an illegal-op error.
- Shifts optionally run iteratively, one bit per cycle.
- Sits between the operand/opcode source (switch/UART loader) and the result sink (LEDs/display/TX).

---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, status flags and illegal-op error.
// Define ALU_SHIFT_ITER_EN to swap the barrel shifter for an iterative 1-bit/cycle shifter.
module alu_seq #(
   parameter int BITS    = 8,
   parameter int OP_BITS = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_BITS-1:0] in_op,
   input  logic [BITS-1:0]    in_a,
   input  logic [BITS-1:0]    in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BITS-1:0]    out_result,
   output logic               out_zero,
   output logic               out_carry,
   output logic               out_overflow,
   output logic               out_err
);
   localparam int SHW = $clog2(BITS);

   localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(6'b100000);
   localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(6'b100010);
   localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(6'b100100);
   localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(6'b100101);
   localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(6'b100110);
   localparam logic [OP_BITS-1:0] OP_NOR = OP_BITS'(6'b100111);
   localparam logic [OP_BITS-1:0] OP_SRL = OP_BITS'(6'b000010);
   localparam logic [OP_BITS-1:0] OP_SRA = OP_BITS'(6'b000011);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state;

   logic [SHW-1:0]  shamt;
   logic            accept;
   logic [BITS:0]   sum;
   logic [BITS:0]   diff;
   logic [BITS-1:0] calc_result;
   logic            calc_carry;
   logic            calc_overflow;
   logic            calc_err;
   logic            calc_zero;

   assign shamt    = in_b[SHW-1:0];
   assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;

   always_comb begin
      sum           = {1'b0, in_a} + {1'b0, in_b};
      diff          = {1'b0, in_a} - {1'b0, in_b};
      calc_result   = '0;
      calc_carry    = 1'b0;
      calc_overflow = 1'b0;
      calc_err      = 1'b0;
      case (in_op)
         OP_ADD: begin
            calc_result   = sum[BITS-1:0];
            calc_carry    = sum[BITS];
            calc_overflow = (in_a[BITS-1] == in_b[BITS-1]) && (sum[BITS-1] != in_a[BITS-1]);
         end
         OP_SUB: begin
            // Top bit of the widened difference is the unsigned borrow (A < B).
            calc_result   = diff[BITS-1:0];
            calc_carry    = diff[BITS];
            calc_overflow = (in_a[BITS-1] != in_b[BITS-1]) && (diff[BITS-1] != in_a[BITS-1]);
         end
         OP_AND: calc_result = in_a & in_b;
         OP_OR:  calc_result = in_a | in_b;
         OP_XOR: calc_result = in_a ^ in_b;
         OP_NOR: calc_result = ~(in_a | in_b);
`ifdef ALU_SHIFT_ITER_EN
         // Only shamt==0 completes here; non-zero shifts go through the iterative path.
         OP_SRL: calc_result = in_a;
         OP_SRA: calc_result = in_a;
`else
         OP_SRL: calc_result = in_a >> shamt;
         OP_SRA: calc_result = $signed(in_a) >>> shamt;
`endif
         default: calc_err = 1'b1;
      endcase
   end

   assign calc_zero = !calc_err && (calc_result == '0);

`ifdef ALU_SHIFT_ITER_EN
   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   logic [BITS-1:0] sh_reg;
   logic            sra_reg;
   logic [SHW-1:0]  count_reg;
   logic [BITS-1:0] step;
   logic            is_shift;

   assign is_shift = (in_op == OP_SRL) || (in_op == OP_SRA);

   genvar gi;
   generate
      for (gi = 0; gi < BITS - 1; gi++) begin : g_step
         assign step[gi] = sh_reg[gi+1];
      end
   endgenerate
   assign step[BITS-1] = sra_reg & sh_reg[BITS-1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_zero     <= 1'b0;
         out_carry    <= 1'b0;
         out_overflow <= 1'b0;
         out_err      <= 1'b0;
`ifdef ALU_SHIFT_ITER_EN
         sh_reg       <= '0;
         sra_reg      <= 1'b0;
         count_reg    <= '0;
`endif
      end else if (accept) begin
`ifdef ALU_SHIFT_ITER_EN
         if (is_shift && (shamt != '0)) begin
            state     <= SHIFT;
            out_valid <= 1'b0;
            sh_reg    <= in_a;
            sra_reg   <= (in_op == OP_SRA);
            count_reg <= shamt;
         end else
`endif
         begin
            state        <= DONE;
            out_valid    <= 1'b1;
            out_result   <= calc_result;
            out_zero     <= calc_zero;
            out_carry    <= calc_carry;
            out_overflow <= calc_overflow;
            out_err      <= calc_err;
         end
      end else begin
         case (state)
`ifdef ALU_SHIFT_ITER_EN
            SHIFT: begin
               sh_reg    <= step;
               count_reg <= count_reg - CNT_ONE;
               if (count_reg == CNT_ONE) begin
                  state        <= DONE;
                  out_valid    <= 1'b1;
                  out_result   <= step;
                  out_zero     <= (step == '0);
                  out_carry    <= 1'b0;
                  out_overflow <= 1'b0;
                  out_err      <= 1'b0;
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq plus hand-written backpressure and reset sequences.
module tb_alu_seq;
   localparam int BITS = 8;
`ifdef ALU_SHIFT_ITER_EN
   localparam bit ITER = 1'b1;
`else
   localparam bit ITER = 1'b0;
`endif

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_ILL = 6'b111111;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [5:0]      in_op = '0;
   logic [BITS-1:0] in_a = '0;
   logic [BITS-1:0] in_b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [BITS-1:0] out_result;
   logic            out_zero;
   logic            out_carry;
   logic            out_overflow;
   logic            out_err;

   int checks = 0;
   int errors = 0;

   alu_seq #(.BITS(BITS), .OP_BITS(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
      .out_overflow(out_overflow), .out_err(out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       v;
      logic       e;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input logic [5:0] op, input logic [7:0] b);
      if (ITER && (op == OP_SRL || op == OP_SRA) && (b[2:0] != 3'd0))
         return int'(b[2:0]) + 1;
      return 1;
   endfunction

   task automatic check_outputs_zero(input string tag);
      check($sformatf("%s.out_valid", tag), 32'(out_valid), 32'd0);
      check($sformatf("%s.out_result", tag), 32'(out_result), 32'd0);
      check($sformatf("%s.flags", tag), {28'd0, out_zero, out_carry, out_overflow, out_err}, 32'd0);
   endtask

   task automatic do_op(input string tag, input vec_t v);
      int lat;
      int exp_lat;
      exp_lat = exp_latency(v.op, v.b);
      @(negedge clk);
      in_op = v.op; in_a = v.a; in_b = v.b; in_valid = 1'b1; out_ready = 1'b0;
      check($sformatf("%s.in_ready", tag), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      // Scramble inputs after acceptance: the DUT must have latched what it needs.
      in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b; in_op = 6'b000000;
      lat = 1;
      while (!out_valid && lat < 40) begin
         check($sformatf("%s.busy_ready", tag), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s.result", tag), 32'(out_result), 32'(v.res));
      check($sformatf("%s.flags_zcve", tag), {28'd0, out_zero, out_carry, out_overflow, out_err},
            {28'd0, v.z, v.c, v.v, v.e});
      $display("%s op=%b a=%h b=%h -> res=%h z=%b c=%b v=%b e=%b lat=%0d", tag, v.op, v.a, v.b,
               out_result, out_zero, out_carry, out_overflow, out_err, lat);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("%s.drained", tag), 32'(out_valid), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{OP_ADD, 8'h82, 8'h01, 8'h83, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{OP_SUB, 8'h82, 8'h01, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{OP_AND, 8'h82, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{OP_OR,  8'h82, 8'h01, 8'h83, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{OP_XOR, 8'h82, 8'h01, 8'h83, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{OP_NOR, 8'h82, 8'h01, 8'h7C, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{OP_SRA, 8'h82, 8'h01, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{OP_SRL, 8'h82, 8'h01, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{OP_SRA, 8'h82, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{OP_SRL, 8'h82, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{OP_SRA, 8'h82, 8'h08, 8'h82, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{OP_SRL, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{OP_SRA, 8'h7F, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{OP_SRA, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{OP_ILL, 8'h82, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[20] = '{6'b000000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state
      #12;
      check_outputs_zero("reset");
      check("reset.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release.in_ready", 32'(in_ready), 32'd1);
      check("release.out_valid", 32'(out_valid), 32'd0);

      for (int i = 0; i < 21; i++)
         do_op($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: result held, no acceptance, then back-to-back handoff
      @(negedge clk);
      in_op = OP_ADD; in_a = 8'h82; in_b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d.result", k), 32'(out_result), 32'h83);
         check($sformatf("bp%0d.flags", k), {28'd0, out_zero, out_carry, out_overflow, out_err}, 32'd0);
         check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_op = OP_SUB; in_a = 8'h80; in_b = 8'h01;
      #1;
      check("b2b.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b.out_valid", 32'(out_valid), 32'd1);
      check("b2b.result", 32'(out_result), 32'h7F);
      check("b2b.flags_zcve", {28'd0, out_zero, out_carry, out_overflow, out_err}, 32'h2);
      $display("backpressure b2b: res=%h ovf=%b", out_result, out_overflow);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("b2b.drained", 32'(out_valid), 32'd0);

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
      in_op = OP_SRA; in_a = 8'h82; in_b = 8'h03; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      check("midrst.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("postrst.in_ready", 32'(in_ready), 32'd1);
      check("postrst.out_valid", 32'(out_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("postrst%0d.no_pulse", k), 32'(out_valid), 32'd0);
      end
      $display("reset sequence: in_ready=%b out_valid=%b", in_ready, out_valid);
      do_op("after_reset", vecs[13]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
